// File: rtl/inv_mode_mixer.sv
// inv_mode_mixer: output mixing stage for the dark-mode video path.
// Owns the {light, src} mode, edits a pending copy on button pulses and makes it
// active on the vsync rising edge. Two-cycle pipeline for syncs and data.
// Optional build macro INV_FADE_EN: cross-fade old -> new mode over 2**FADE_LOG2 frames.
module inv_mode_mixer #(
  parameter int unsigned NSRC      = 3,
  parameter int unsigned NCH       = 3,
  parameter int unsigned BPC       = 8,
  parameter int unsigned FADE_LOG2 = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       hs_i,
  input  logic                       vs_i,
  input  logic                       de_i,
  input  logic [NCH*BPC-1:0]         data_i,
  input  logic [NSRC-1:0]            x_i,
  input  logic                       cycle_i,
  input  logic                       pol_i,
  input  logic                       bypass_i,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic                       de_o,
  output logic [NCH*BPC-1:0]         data_o,
  output logic [$clog2(NSRC+1):0]    mode_o,
  output logic                       busy_o
);

  localparam int unsigned SW = $clog2(NSRC + 1);
  localparam int unsigned MW = SW + 1;
  localparam int unsigned DW = NCH * BPC;
  localparam logic [MW-1:0] MODE_RST = MW'(1);

  // Elaboration-time guard on parameter ranges
  if (NSRC < 1 || NSRC > 7 || FADE_LOG2 < 1 || FADE_LOG2 > 16) begin : g_param_check
    $error("inv_mode_mixer: parameter out of range");
  end

  logic [MW-1:0] pend_q, pend_d, act_q, act_d;
  logic          busy_q, busy_d;
  logic          hs1_q, vs1_q, de1_q, inv1_q, inv1_d;
  logic [DW-1:0] data1_q;
  logic          hs2_q, vs2_q, de2_q;
  logic [DW-1:0] data2_q, data2_d;
  logic          vs_edge_c;

  // Invert decision of a mode: light alone for DIRECT/INV, else light xor chosen source
  function automatic logic mode_inv(input logic [MW-1:0] m, input logic [NSRC-1:0] x);
    logic r;
    r = m[SW];
    for (int k = 0; k < NSRC; k++) begin
      if (m[SW-1:0] == SW'(k + 1)) r = m[SW] ^ x[k];
    end
    return r;
  endfunction

  assign vs_edge_c = vs_i & ~vs1_q;

  // Mode next state: pulses edit pending, vsync rising edge copies pending to active
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (cycle_i) pend_d[SW-1:0] = (pend_q[SW-1:0] == SW'(NSRC)) ? '0 : pend_q[SW-1:0] + SW'(1);
    if (pol_i)   pend_d[SW]     = ~pend_q[SW];
    if (vs_edge_c) act_d = pend_q;
  end

  // Stage-1 invert decision for the active mode; bypass overrides without touching mode
  always_comb begin
    inv1_d = ~bypass_i & mode_inv(act_q, x_i);
  end

`ifdef INV_FADE_EN
  localparam int unsigned AW = FADE_LOG2 + 1;
  localparam int unsigned PW = BPC + FADE_LOG2 + 1;
  localparam logic [AW-1:0] A_FULL = AW'(2 ** FADE_LOG2);

  logic [MW-1:0]  old_q, old_d;
  logic [AW-1:0]  a_q, a_d, a1_q;
  logic           inv_old1_q, inv_old_d;
  logic [PW-1:0]  acc_c;
  logic [BPC-1:0] p_old_c, p_new_c;

  // Alpha: restart on a real mode change, otherwise step once per frame up to full
  always_comb begin
    old_d = old_q;
    a_d   = a_q;
    if (vs_edge_c && (pend_q != act_q)) begin
      old_d = act_q;
      a_d   = '0;
    end else if (vs_edge_c && (a_q != A_FULL)) begin
      a_d = a_q + AW'(1);
    end
    inv_old_d = ~bypass_i & mode_inv(old_q, x_i);
    busy_d    = (pend_d != act_d) | (a_d != A_FULL);
  end

  // Stage-2 blend of old-mode and new-mode pixels, per channel
  always_comb begin
    data2_d = '0;
    acc_c   = '0;
    p_old_c = '0;
    p_new_c = '0;
    for (int c = 0; c < NCH; c++) begin
      p_old_c = data1_q[c*BPC +: BPC] ^ {BPC{inv_old1_q}};
      p_new_c = data1_q[c*BPC +: BPC] ^ {BPC{inv1_q}};
      acc_c   = PW'(p_old_c) * PW'(A_FULL - a1_q) + PW'(p_new_c) * PW'(a1_q);
      data2_d[c*BPC +: BPC] = BPC'(acc_c >> FADE_LOG2);
    end
  end

  // Fade state and its stage-1 companions
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      old_q      <= MODE_RST;
      a_q        <= A_FULL;
      a1_q       <= A_FULL;
      inv_old1_q <= 1'b0;
    end else begin
      old_q      <= old_d;
      a_q        <= a_d;
      a1_q       <= a_q;
      inv_old1_q <= inv_old_d;
    end
  end
`else
  // Stage-2 instantaneous invert
  always_comb begin
    data2_d = data1_q ^ {DW{inv1_q}};
    busy_d  = (pend_d != act_d);
  end
`endif

  // Mode registers and busy flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= MODE_RST;
      act_q  <= MODE_RST;
      busy_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      busy_q <= busy_d;
    end
  end

  // Two-stage pixel/sync pipeline
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      data1_q <= '0;
      inv1_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de2_q   <= 1'b0;
      data2_q <= '0;
    end else begin
      hs1_q   <= hs_i;
      vs1_q   <= vs_i;
      de1_q   <= de_i;
      data1_q <= data_i;
      inv1_q  <= inv1_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      de2_q   <= de1_q;
      data2_q <= data2_d;
    end
  end

  assign hs_o   = hs2_q;
  assign vs_o   = vs2_q;
  assign de_o   = de2_q;
  assign data_o = data2_q;
  assign mode_o = act_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_inv_mode_mixer.sv
// Testbench for inv_mode_mixer: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model. Honours INV_FADE_EN.
module tb_inv_mode_mixer;

  localparam int NSRC = 3;
  localparam int FL2  = 2;
  localparam int F    = 4;

  logic        clk = 1'b0;
  logic        rst_n, hs, vs, de, cyc, pol, byp;
  logic [23:0] data;
  logic [2:0]  x;
  logic        hs_o, vs_o, de_o, busy_o;
  logic [23:0] data_o;
  logic [2:0]  mode_o;

  int n_checks = 0;
  int n_errors = 0;

  inv_mode_mixer #(.NSRC(NSRC), .NCH(3), .BPC(8), .FADE_LOG2(FL2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hs_i(hs), .vs_i(vs), .de_i(de), .data_i(data),
    .x_i(x), .cycle_i(cyc), .pol_i(pol), .bypass_i(byp),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o), .mode_o(mode_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { logic hs; logic vs; logic de; logic [23:0] d; } px_t;
  px_t q[$];
  int  m_psrc = 1, m_plight = 0, m_asrc = 1, m_alight = 0;
  int  m_osrc = 1, m_olight = 0, m_a = F;
  bit  m_vsprev = 0;
  px_t e;
  logic [2:0] e_mode;
  logic       e_busy;

  function automatic int inv_of(int light, int src, logic [2:0] xx);
    if (src == 0) return light;
    return light ^ int'(xx[src-1]);
  endfunction

`ifdef INV_FADE_EN
  function automatic logic [23:0] mix(logic [23:0] d, int io, int in_, int a);
    int ch, po, pn;
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ch = int'((d >> (8 * c)) & 24'hFF);
      po = io ? 255 - ch : ch;
      pn = in_ ? 255 - ch : ch;
      r  = r | (24'((po * (F - a) + pn * a) / F) << (8 * c));
    end
    return r;
  endfunction
`endif

  // One clock: predict what the current inputs produce, advance, refresh expectations
  task automatic step();
    px_t n;
    int  in_;
    in_ = byp ? 0 : inv_of(m_alight, m_asrc, x);
`ifdef INV_FADE_EN
    n.d = mix(data, byp ? 0 : inv_of(m_olight, m_osrc, x), in_, m_a);
`else
    n.d = in_ ? ~data : data;
`endif
    n.hs = hs; n.vs = vs; n.de = de;
    @(posedge clk);
    if (!rst_n) begin
      m_psrc = 1; m_plight = 0; m_asrc = 1; m_alight = 0;
      m_osrc = 1; m_olight = 0; m_a = F; m_vsprev = 0;
      q.delete();
      n = '{1'b0, 1'b0, 1'b0, 24'h0};
      q.push_back(n); q.push_back(n);
    end else begin
      void'(q.pop_front());
      q.push_back(n);
      if (vs && !m_vsprev) begin
        if (m_psrc != m_asrc || m_plight != m_alight) begin
          m_osrc = m_asrc; m_olight = m_alight; m_a = 0;
        end else if (m_a < F) begin
          m_a++;
        end
        m_asrc = m_psrc; m_alight = m_plight;
      end
      if (cyc) m_psrc = (m_psrc == NSRC) ? 0 : m_psrc + 1;
      if (pol) m_plight ^= 1;
      m_vsprev = vs;
    end
    #1;
    e      = q[0];
    e_mode = 3'(m_alight * 4 + m_asrc);
    e_busy = (m_psrc != m_asrc) || (m_plight != m_alight);
`ifdef INV_FADE_EN
    e_busy = e_busy || (m_a != F);
`endif
  endtask

  task automatic vs_pulse();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  task automatic pulse(input bit c, input bit p);
    cyc = c; pol = p; step();
    cyc = 1'b0; pol = 1'b0; step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = 24'h123456; x = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({hs_o, vs_o, de_o, busy_o} !== 4'b0 || data_o !== 24'h0 || mode_o !== 3'b001) begin
        n_errors++;
        $display("FAIL reset_state: syncs/busy=%b data=%h mode=%b, want 0000 000000 001",
                 {hs_o, vs_o, de_o, busy_o}, data_o, mode_o);
      end
    end
    rst_n = 1'b1;
    step(); step();
    n_checks++;
    if (data_o !== 24'h123456 || mode_o !== 3'b001) begin
      n_errors++;
      $display("FAIL reset_release: data=%h mode=%b, want 123456 001", data_o, mode_o);
    end
  endtask

  task automatic test_invert();
    x = 3'b001; data = 24'h00FF10;
    step(); step();
    n_checks++;
    if (data_o !== 24'hFF00EF) begin
      n_errors++;
      $display("FAIL invert_src1: data=%h, want ff00ef", data_o);
    end
    x = 3'b000;
    step(); step();
    n_checks++;
    if (data_o !== 24'h00FF10) begin
      n_errors++;
      $display("FAIL direct_src1: data=%h, want 00ff10", data_o);
    end
  endtask

  task automatic test_mode_cycle();
    pulse(1'b1, 1'b0);
    n_checks++;
    if (mode_o !== 3'b001 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL pending_midframe: mode=%b busy=%b, want 001 1", mode_o, busy_o);
    end
    vs = 1'b1; step();
    n_checks++;
    if (mode_o !== 3'b010) begin
      n_errors++;
      $display("FAIL apply_at_vs: mode=%b, want 010", mode_o);
    end
`ifndef INV_FADE_EN
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_after_apply: busy=%b, want 0", busy_o);
    end
`endif
    vs = 1'b0; step();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    vs_pulse();
    n_checks++;
    if (mode_o !== 3'b001) begin
      n_errors++;
      $display("FAIL src_wrap: mode=%b, want 001", mode_o);
    end
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    vs_pulse();
    n_checks++;
    if (mode_o !== 3'b011) begin
      n_errors++;
      $display("FAIL reach_src3: mode=%b, want 011", mode_o);
    end
  endtask

  task automatic test_both_pulses();
    pulse(1'b1, 1'b1);
    vs_pulse();
    n_checks++;
    if (mode_o !== 3'b100) begin
      n_errors++;
      $display("FAIL both_pulses: mode=%b, want 100", mode_o);
    end
    data = 24'h000000;
    for (int i = 0; i < 4; i++) begin
      x = 3'($urandom_range(0, 7));
      step(); step();
      n_checks++;
      if (data_o !== e.d) begin
        n_errors++;
        $display("FAIL inv_mode_model: data=%h, want %h", data_o, e.d);
      end
`ifndef INV_FADE_EN
      n_checks++;
      if (data_o !== 24'hFFFFFF) begin
        n_errors++;
        $display("FAIL inv_mode_const: data=%h, want ffffff", data_o);
      end
`endif
    end
  endtask

  task automatic test_bypass();
    byp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = 24'($urandom); x = 3'($urandom_range(0, 7));
      step(); step();
      n_checks++;
      if (data_o !== data || mode_o !== 3'b100) begin
        n_errors++;
        $display("FAIL bypass: data=%h mode=%b, want %h 100", data_o, mode_o, data);
      end
    end
    byp = 1'b0;
  endtask

`ifdef INV_FADE_EN
  task automatic test_fade();
    logic [7:0] fexp [5];
    fexp = '{8'h00, 8'h3F, 8'h7F, 8'hBF, 8'hFF};
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) vs_pulse();
    pulse(1'b0, 1'b1);
    vs_pulse();
    data = 24'h0;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if (data_o !== {3{fexp[f]}} || busy_o !== (f < 4)) begin
        n_errors++;
        $display("FAIL fade_frame%0d: data=%h busy=%b, want %h %b",
                 f, data_o, busy_o, {3{fexp[f]}}, (f < 4));
      end
      vs_pulse();
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      hs    = 1'($urandom); de = 1'($urandom);
      vs    = ($urandom_range(0, 29) == 0);
      cyc   = ($urandom_range(0, 14) == 0);
      pol   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) byp = ~byp;
      data  = 24'($urandom); x = 3'($urandom_range(0, 7));
      step();
      n_checks++;
      if ({hs_o, vs_o, de_o} !== {e.hs, e.vs, e.de} || data_o !== e.d ||
          mode_o !== e_mode || busy_o !== e_busy) begin
        n_errors++;
        $display("FAIL random[%0d]: syncs=%b data=%h mode=%b busy=%b, want %b %h %b %b",
                 i, {hs_o, vs_o, de_o}, data_o, mode_o, busy_o,
                 {e.hs, e.vs, e.de}, e.d, e_mode, e_busy);
      end
    end
    rst_n = 1'b1; vs = 1'b0; cyc = 1'b0; pol = 1'b0; byp = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; cyc = 1'b0; pol = 1'b0; byp = 1'b0;
    data = '0; x = '0;
    test_reset();
    test_invert();
    test_mode_cycle();
    test_both_pulses();
    test_bypass();
`ifdef INV_FADE_EN
    test_fade();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
